multi_edge_detect: RTL and testbench
====================================

# multi_edge_detect

Multi-channel edge detector for asynchronous or noisy single-bit inputs, one channel per bit of `din`. Each channel has an input synchroniser, an optional glitch filter, registered rise/fall pulses and a sticky pending flag with overflow. A per-channel mode selects which edges raise the pending flag. It sits between raw board/peripheral signals and the interrupt/status logic, replacing single-channel unfiltered edge detection.

## Interface
- `CH`, 8: number of channels (≥1).
- `SYNC`, 2: synchroniser stages (0–3); 0 means `din` is already synchronous to `clk`.
- `FILT`, 4: stability count in cycles (1–255); only used when the filter is compiled in.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  CH  raw inputs.
- `mode`  in  2*CH  per channel i, `mode[2i+1:2i]`: 00 off, 01 rise, 10 fall, 11 both.
- `clr`  in  CH  write-1-to-clear for `pend[i]`/`ovf[i]`; level-sampled every cycle.
- `level`  out  CH  filtered, registered level.
- `rise`  out  CH  one-cycle pulse, first cycle `level[i]`=1.
- `fall`  out  CH  one-cycle pulse, first cycle `level[i]`=0.
- `pend`  out  CH  sticky qualified-event flag.
- `ovf`  out  CH  sticky: qualified event while `pend[i]` already set.
- `irq`  out  1  OR of `pend`, driven from registers with no added latency.

## Operation
- Reset: sync flops, filter counters, `level`, `rise`, `fall`, `pend`, `ovf` all 0; `irq`=0. Reset mid-operation discards filter progress on the next edge.
- Sync: `SYNC` flops per channel; output `s[i]`.
- Filter (macro on): per-channel counter, width max(1,$clog2(FILT)).
  - `s[i]==level[i]`: counter ← 0.
  - Mismatch with counter < `FILT`-1: counter++.
  - Mismatch with counter == `FILT`-1: `level[i]` ← `s[i]`, counter ← 0, `rise[i]`/`fall[i]` set for one cycle.
  - A single matching cycle restarts the count. Pulses narrower than `FILT` cycles never reach `level`.
- Edge pulses: `rise[i]` = 1 only in the cycle after `level[i]` changes 0→1; `fall[i]` likewise for 1→0. Never both at once.
- Qualified event: `evt[i]` = (`rise[i]` & `mode[2i]`) | (`fall[i]` & `mode[2i+1]`), using `mode` as sampled in the same cycle.
- Pending/overflow update, per edge:
  - Clear first: `clr[i]` drives both `pend[i]` and `ovf[i]` toward 0.
  - Then set: `evt[i]` → `pend[i]` ← 1.
  - `evt[i]` & `pend[i]` & ~`clr[i]` → `ovf[i]` ← 1.
  - Same-cycle `clr`+`evt` gives `pend`=1, `ovf`=0.
- Mode off (00) still updates `level`/`rise`/`fall` and never sets `pend`. Changing `mode` does not alter `pend`/`ovf`.

## Timing
- `din[i]` first sampled at new value at edge 0 and held stable: `level[i]` and `rise`/`fall` update at edge `SYNC`+`FILT`-1, visible the following cycle.
- `pend[i]` updates one edge later than `rise`/`fall`. `irq` follows `pend` in the same cycle.
- Filter compiled out: behaves as `FILT`=1, giving latency `SYNC`+1 edges.
- Minimum event spacing per channel: `FILT` cycles. Back-to-back edges at this spacing each produce one pulse.

## Configuration
- `MULTI_EDGE_DETECT_FILTER_EN`
  - Defined: glitch filter per channel as specified; `FILT` is honoured.
  - Undefined: no counters; `level[i]` ← `s[i]` every cycle; `FILT` is ignored; every `s` transition produces a pulse.

## Test plan
- `SYNC`=2, `FILT`=4, ch0 mode 01: `din[0]` 0→1 held → `level[0]`/`rise[0]` high after edge 5, `rise` exactly 1 cycle; `pend[0]`=1 a cycle later; `irq`=1.
- 3-cycle high glitch on `din[1]` → no `level`/`rise`/`fall`/`pend` change; 4-cycle high → one `rise` then one `fall`.
- ch2 mode 10: two `fall` events without `clr` → `pend[2]`=1, `ovf[2]`=1; assert `clr[2]` one cycle → both 0, `irq` drops if no other pend.
- `clr[3]` asserted in the same cycle as a qualified `rise[3]` → `pend[3]`=1, `ovf[3]`=0.
- Mode 00 on ch4 with toggling input → `rise`/`fall` pulse, `pend[4]` stays 0; `rst` during a filter count → all outputs 0 next cycle, count restarts from 0.
- Macro undefined, `SYNC`=0: `din` toggling every cycle → `rise`/`fall` alternating each cycle, latency 1 edge.

Source files
------------

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: per-channel synchroniser, glitch filter (MULTI_EDGE_DETECT_FILTER_EN), edge pulses, sticky pend/ovf and irq
module multi_edge_detect #(
  parameter int CH = 8,
  parameter int SYNC = 2,
  parameter int FILT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   din,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic [CH-1:0]   pend,
  output logic [CH-1:0]   ovf,
  output logic            irq
);
  logic [CH-1:0] s, nxt_level, evt;
  if (SYNC == 0) begin : g_nosync
    assign s = din;
  end else begin : g_sync
    logic [CH-1:0] sq [SYNC];
    always_ff @(posedge clk)
      if (rst) sq <= '{default: '0};
      else begin
        sq[0] <= din;
        for (int k = 1; k < SYNC; k++) sq[k] <= sq[k-1];
      end
    assign s = sq[SYNC-1];
  end
`ifdef MULTI_EDGE_DETECT_FILTER_EN
  localparam int CW = FILT > 1 ? $clog2(FILT) : 1;
  logic [CW-1:0] cnt [CH];
  logic [CH-1:0] done;
  always_comb begin
    done = '0;
    for (int i = 0; i < CH; i++) done[i] = s[i] != level[i] && cnt[i] == CW'(FILT - 1);
  end
  // any matching cycle or a completed run restarts the stability count
  always_ff @(posedge clk)
    if (rst) cnt <= '{default: '0};
    else for (int i = 0; i < CH; i++) cnt[i] <= (s[i] == level[i] || done[i]) ? '0 : cnt[i] + CW'(1);
  assign nxt_level = (level & ~done) | (s & done);
`else
  assign nxt_level = s;
`endif
  always_comb begin
    evt = '0;
    for (int i = 0; i < CH; i++) evt[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
  end
  // clear takes priority over overflow, but a same-cycle event still sets pend
  always_ff @(posedge clk)
    if (rst) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      pend  <= '0;
      ovf   <= '0;
    end else begin
      level <= nxt_level;
      rise  <= nxt_level & ~level;
      fall  <= ~nxt_level & level;
      pend  <= (pend & ~clr) | evt;
      ovf   <= (ovf & ~clr) | (evt & pend & ~clr);
    end
  assign irq = |pend;
endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect: randomized and directed checks against a history-based reference model
module tb_multi_edge_detect;
  localparam int CH = 8, SYNC = 2, FILT = 4;
`ifdef MULTI_EDGE_DETECT_FILTER_EN
  localparam int EF = FILT;
`else
  localparam int EF = 1;
`endif
  logic clk = 0, rst = 1;
  logic [CH-1:0] din = '0, clr = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0] level, rise, fall, pend, ovf;
  logic irq;
  logic d1 = 0;
  logic l1, r1, f1, p1, o1, i1;
  int checks = 0, passes = 0;

  multi_edge_detect #(.CH(CH), .SYNC(SYNC), .FILT(FILT)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .level(level), .rise(rise), .fall(fall), .pend(pend), .ovf(ovf), .irq(irq));

  multi_edge_detect #(.CH(1), .SYNC(0), .FILT(1)) dut0 (
    .clk(clk), .rst(rst), .din(d1), .mode(2'b11), .clr(1'b0),
    .level(l1), .rise(r1), .fall(f1), .pend(p1), .ovf(o1), .irq(i1));

  always #5 clk = ~clk;

  // model: level flips once the last EF synchronised samples all differ from it
  logic [CH-1:0] ms [SYNC];
  logic [CH-1:0] sh [$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_pend, m_ovf;
  logic [5*CH:0] mod_v, dut_v;
  assign dut_v = {level, rise, fall, pend, ovf, irq};

  task automatic model_step();
    logic [CH-1:0] s, nl, evt;
    bit all;
    if (rst) begin
      foreach (ms[k]) ms[k] = '0;
      sh.delete();
      {m_level, m_rise, m_fall, m_pend, m_ovf} = '0;
    end else begin
      s = ms[SYNC-1];
      sh.push_back(s);
      if (sh.size() > EF) void'(sh.pop_front());
      nl = m_level;
      for (int i = 0; i < CH; i++) begin
        all = sh.size() == EF;
        foreach (sh[k]) if (sh[k][i] == m_level[i]) all = 0;
        if (all) nl[i] = ~m_level[i];
        evt[i] = (m_rise[i] & mode[2*i]) | (m_fall[i] & mode[2*i+1]);
      end
      m_ovf  = (m_ovf & ~clr) | (evt & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | evt;
      m_rise = nl & ~m_level;
      m_fall = ~nl & m_level;
      m_level = nl;
      for (int k = SYNC - 1; k > 0; k--) ms[k] = ms[k-1];
      ms[0] = din;
    end
    mod_v = {m_level, m_rise, m_fall, m_pend, m_ovf, |m_pend};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    din = CH'($urandom);
    repeat (3) tick();
    checks++;
    if (dut_v !== '0) $display("FAIL reset dut=%h want=0", dut_v); else passes++;
    checks++;
    if (dut_v !== mod_v) $display("FAIL reset_model dut=%h model=%h", dut_v, mod_v); else passes++;
    din = '0;
    repeat (3) tick();
    rst = 0;
  endtask

  task automatic test_rise();
    int lat = -1, pl = -1, nr = 0;
    mode[1:0] = 2'b01;
    din[0] = 1;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (level[0] && lat < 0) lat = t;
      if (pend[0] && pl < 0) pl = t;
      nr += int'(rise[0]);
      checks++;
      if (dut_v !== mod_v) $display("FAIL rise_model t%0d dut=%h model=%h", t, dut_v, mod_v); else passes++;
    end
    checks++;
    if (lat != SYNC + EF - 1) $display("FAIL rise_latency got %0d want %0d", lat, SYNC + EF - 1); else passes++;
    checks++;
    if (pl != lat + 1) $display("FAIL pend_latency got %0d want %0d", pl, lat + 1); else passes++;
    checks++;
    if (nr != 1) $display("FAIL rise_width got %0d want 1", nr); else passes++;
    checks++;
    if (irq !== 1'b1) $display("FAIL rise_irq got %b want 1", irq); else passes++;
  endtask

  task automatic glitch(input int len, output int nr, output int nf, output logic pd);
    nr = 0;
    nf = 0;
    din[1] = 1;
    for (int t = 0; t < len + 12; t++) begin
      if (t == len) din[1] = 0;
      tick();
      nr += int'(rise[1]);
      nf += int'(fall[1]);
      checks++;
      if (dut_v !== mod_v) $display("FAIL glitch%0d_model dut=%h model=%h", len, dut_v, mod_v); else passes++;
    end
    pd = pend[1];
  endtask

  task automatic test_glitch();
    int nr, nf;
    logic pd;
    mode[3:2] = 2'b11;
    glitch(3, nr, nf, pd);
    checks++;
    if ({nr, nf} != {(3 >= EF) ? 1 : 0, (3 >= EF) ? 1 : 0})
      $display("FAIL glitch3 rise/fall %0d/%0d want %0d", nr, nf, (3 >= EF) ? 1 : 0); else passes++;
    checks++;
    if (pd !== (3 >= EF)) $display("FAIL glitch3_pend got %b want %b", pd, 3 >= EF); else passes++;
    clr[1] = 1;
    tick();
    clr[1] = 0;
    glitch(4, nr, nf, pd);
    checks++;
    if (nr != 1 || nf != 1) $display("FAIL glitch4 rise/fall %0d/%0d want 1/1", nr, nf); else passes++;
  endtask

  task automatic test_ovf();
    mode[5:4] = 2'b10;
    foreach (din[k]) begin end
    for (int e = 0; e < 4; e++) begin
      din[2] = (e % 2 == 0);
      repeat (12) begin
        tick();
        checks++;
        if (dut_v !== mod_v) $display("FAIL ovf_model dut=%h model=%h", dut_v, mod_v); else passes++;
      end
    end
    checks++;
    if ({pend[2], ovf[2]} !== 2'b11) $display("FAIL ovf_set pend/ovf=%b want 11", {pend[2], ovf[2]}); else passes++;
    clr[2] = 1;
    tick();
    clr[2] = 0;
    tick();
    checks++;
    if ({pend[2], ovf[2]} !== 2'b00) $display("FAIL ovf_clr pend/ovf=%b want 00", {pend[2], ovf[2]}); else passes++;
    clr = '1;
    tick();
    clr = '0;
    tick();
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_drop got %b want 0", irq); else passes++;
  endtask

  task automatic test_clr_same();
    int t = 0;
    mode[7:6] = 2'b01;
    din[3] = 1;
    repeat (12) tick();
    din[3] = 0;
    repeat (12) tick();
    checks++;
    if (pend[3] !== 1'b1) $display("FAIL clr_same_pre pend=%b want 1", pend[3]); else passes++;
    din[3] = 1;
    while (!rise[3] && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (!rise[3]) $display("FAIL clr_same_wait rise=%b want 1 within 20", rise[3]); else passes++;
    clr[3] = 1;
    tick();
    clr[3] = 0;
    checks++;
    if ({pend[3], ovf[3]} !== 2'b10) $display("FAIL clr_same pend/ovf=%b want 10", {pend[3], ovf[3]}); else passes++;
    checks++;
    if (dut_v !== mod_v) $display("FAIL clr_same_model dut=%h model=%h", dut_v, mod_v); else passes++;
  endtask

  task automatic test_mode_off_reset();
    int nr = 0, nf = 0, lat = -1;
    mode[9:8] = 2'b00;
    for (int e = 0; e < 6; e++) begin
      din[4] = ~din[4];
      repeat (10) begin
        tick();
        nr += int'(rise[4]);
        nf += int'(fall[4]);
      end
    end
    checks++;
    if (nr != 3 || nf != 3 || pend[4] !== 1'b0)
      $display("FAIL mode_off rise/fall/pend %0d/%0d/%b want 3/3/0", nr, nf, pend[4]); else passes++;
    mode[11:10] = 2'b01;
    din[5] = 1;
    repeat (3) tick();
    rst = 1;
    tick();
    checks++;
    if (dut_v !== '0) $display("FAIL mid_reset dut=%h want=0", dut_v); else passes++;
    rst = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (level[5] && lat < 0) lat = t;
    end
    checks++;
    if (lat != SYNC + EF - 1) $display("FAIL reset_restart latency %0d want %0d", lat, SYNC + EF - 1); else passes++;
    checks++;
    if (dut_v !== mod_v) $display("FAIL reset_model dut=%h model=%h", dut_v, mod_v); else passes++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) mode = 2*CH'($urandom);
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
      for (int i = 0; i < CH; i++) clr[i] = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (dut_v !== mod_v) $display("FAIL random c%0d dut=%h model=%h", c, dut_v, mod_v); else passes++;
    end
    rst = 0;
    clr = '0;
  endtask

  task automatic test_sync0();
    logic prev = l1;
    for (int c = 0; c < 10; c++) begin
      d1 = ~d1;
      tick();
      checks++;
      if ({l1, r1, f1} !== {d1, d1 & ~prev, ~d1 & prev})
        $display("FAIL sync0 c%0d l/r/f=%b want %b", c, {l1, r1, f1}, {d1, d1 & ~prev, ~d1 & prev}); else passes++;
      prev = d1;
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_ovf();
    test_clr_same();
    test_mode_off_reset();
    test_sync0();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
